// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic memory-game player.
// State encodings (their values appear on db_estado) and small LED/button helpers.
package jogador_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PULSA_JOGAR = 4'h1,
    OBSERVA     = 4'h2,
    PRESSIONA   = 4'h3,
    SOLTA       = 4'h4,
    FIM         = 4'hF
  } estado_t;

  // True when exactly one of the four bits is set.
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Rotate left by one position; turns a correct press into a wrong one.
  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/memoria_jogadas.sv
// Sequence store for the automatic player.
// Ports: clock/reset; limpa clears the write pointer and overflow flag;
// escreve/dado append one entry; end_leitura/dado_lido form the asynchronous
// read port; contagem is the number of entries held; overflow flags appends
// attempted while full (those entries are dropped).
module memoria_jogadas #(
  parameter  int unsigned MAX_JOGADAS = 16,
  localparam int unsigned CW = $clog2(MAX_JOGADAS + 1),
  localparam int unsigned AW = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          limpa,
  input  logic          escreve,
  input  logic [3:0]    dado,
  input  logic [CW-1:0] end_leitura,
  output logic [3:0]    dado_lido,
  output logic [CW-1:0] contagem,
  output logic          overflow
);

  logic [3:0]    r_mem [MAX_JOGADAS];
  logic [CW-1:0] r_cont;
  logic          r_overflow;
  logic          w_cheia;
  logic          w_grava;

  assign w_cheia = (r_cont >= CW'(MAX_JOGADAS));
  assign w_grava = escreve && !limpa && !reset && !w_cheia;

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      r_cont     <= '0;
      r_overflow <= 1'b0;
    end else if (escreve) begin
      if (w_cheia) r_overflow <= 1'b1;
      else         r_cont     <= r_cont + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_grava) r_mem[r_cont[AW-1:0]] <= dado;
  end

  assign dado_lido = r_mem[end_leitura[AW-1:0]];
  assign contagem  = r_cont;
  assign overflow  = r_overflow;

endmodule

// File: rtl/jogador_automatico.sv
// Autonomous player for the memory game: pulses jogar, records the LED
// sequence the game presents, then replays it on botoes with fixed
// press/release timing. Optionally corrupts the first press of one round.
// Ports: clock, reset (sync, active-high), habilita, leds, pronto, ganhou,
// perdeu in; jogar, botoes, terminou, venceu and db_* debug outputs out.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter  int unsigned MAX_JOGADAS  = 16,
  parameter  int unsigned PRESS_CYCLES = 10,
  parameter  int unsigned GAP_CYCLES   = 10,
  parameter  int unsigned QUIET_CYCLES = 20,
  parameter  int unsigned JOGAR_CYCLES = 5,
  parameter  int unsigned ERRO_RODADA  = 0,
  localparam int unsigned CW = $clog2(MAX_JOGADAS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          habilita,
  input  logic [3:0]    leds,
  input  logic          pronto,
  input  logic          ganhou,
  input  logic          perdeu,
  output logic          jogar,
  output logic [3:0]    botoes,
  output logic          terminou,
  output logic          venceu,
  output logic          db_overflow,
  output logic [3:0]    db_estado,
  output logic [3:0]    db_rodada,
  output logic [CW-1:0] db_contagem
);

  localparam logic [15:0] T_JOGAR = 16'(JOGAR_CYCLES - 1);
  localparam logic [15:0] T_QUIET = 16'(QUIET_CYCLES - 1);
  localparam logic [15:0] T_PRESS = 16'(PRESS_CYCLES - 1);
  localparam logic [15:0] T_GAP   = 16'(GAP_CYCLES - 1);

  estado_t       r_estado;
  logic          r_jogar;
  logic [3:0]    r_botoes;
  logic          r_terminou;
  logic          r_venceu;
  logic [3:0]    r_rodada;
  logic [3:0]    r_leds_ant;
  logic [CW-1:0] r_indice;
  logic [15:0]   r_timer;

  logic          w_fim_jogo;
  logic          w_segue;
  logic          w_captura;
  logic          w_limpa;
  logic [CW-1:0] w_indice_prox;
  logic          w_ha_proxima;
  logic [CW-1:0] w_end_leitura;
  logic [3:0]    w_dado_lido;
  logic [CW-1:0] w_contagem;
  logic          w_overflow;
  logic [3:0]    w_rodada_prox;
  logic          w_erro;

  assign w_fim_jogo    = (r_estado != INICIAL) && (pronto || ganhou || perdeu);
  assign w_segue       = habilita && !w_fim_jogo;
  assign w_captura     = w_segue && (r_estado == OBSERVA) &&
                         (r_leds_ant == 4'b0000) && eh_one_hot(leds);
  assign w_indice_prox = r_indice + CW'(1);
  assign w_ha_proxima  = (w_indice_prox < w_contagem);
  // Read-ahead: during SOLTA the next entry is presented; elsewhere entry 0.
  assign w_end_leitura = (r_estado == SOLTA) ? w_indice_prox : '0;
  assign w_rodada_prox = (r_rodada == 4'hF) ? 4'hF : r_rodada + 4'd1;
  assign w_erro        = (ERRO_RODADA != 0) && (w_rodada_prox == 4'(ERRO_RODADA));
  // Pointer clear coincides with every FSM transition into OBSERVA.
  assign w_limpa       = w_segue &&
                         (((r_estado == PULSA_JOGAR) && (r_timer == T_JOGAR)) ||
                          ((r_estado == SOLTA) && (r_timer == T_GAP) && !w_ha_proxima));

  memoria_jogadas #(.MAX_JOGADAS(MAX_JOGADAS)) u_memoria (
    .clock       (clock),
    .reset       (reset),
    .limpa       (w_limpa),
    .escreve     (w_captura),
    .dado        (leds),
    .end_leitura (w_end_leitura),
    .dado_lido   (w_dado_lido),
    .contagem    (w_contagem),
    .overflow    (w_overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) r_leds_ant <= '0;
    else       r_leds_ant <= leds;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= INICIAL;
      r_jogar    <= 1'b0;
      r_botoes   <= '0;
      r_terminou <= 1'b0;
      r_venceu   <= 1'b0;
      r_rodada   <= '0;
      r_indice   <= '0;
      r_timer    <= '0;
    end else if (!habilita) begin
      r_estado   <= INICIAL;
      r_jogar    <= 1'b0;
      r_botoes   <= '0;
      r_terminou <= 1'b0;
      r_timer    <= '0;
    end else if (w_fim_jogo && (r_estado != FIM)) begin
      r_estado   <= FIM;
      r_jogar    <= 1'b0;
      r_botoes   <= '0;
      r_terminou <= 1'b1;
      r_venceu   <= ganhou;
      r_timer    <= '0;
    end else begin
      case (r_estado)
        INICIAL: begin
          r_estado <= PULSA_JOGAR;
          r_jogar  <= 1'b1;
          r_rodada <= '0;
          r_timer  <= '0;
        end
        PULSA_JOGAR: begin
          if (r_timer == T_JOGAR) begin
            r_estado <= OBSERVA;
            r_jogar  <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        OBSERVA: begin
          if (leds != 4'b0000) begin
            r_timer <= '0;
          end else if (w_contagem != '0) begin
            if (r_timer == T_QUIET) begin
              r_estado <= PRESSIONA;
              r_timer  <= '0;
              r_indice <= '0;
              r_rodada <= w_rodada_prox;
              r_botoes <= w_erro ? rotl1(w_dado_lido) : w_dado_lido;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
        end
        PRESSIONA: begin
          if (r_timer == T_PRESS) begin
            r_estado <= SOLTA;
            r_botoes <= '0;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        SOLTA: begin
          if (r_timer == T_GAP) begin
            r_timer <= '0;
            if (w_ha_proxima) begin
              r_estado <= PRESSIONA;
              r_indice <= w_indice_prox;
              r_botoes <= w_dado_lido;
            end else begin
              r_estado <= OBSERVA;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        FIM: begin
          r_botoes <= '0;
        end
        default: begin
          r_estado <= INICIAL;
        end
      endcase
    end
  end

  assign jogar       = r_jogar && habilita;
  assign botoes      = w_segue ? r_botoes : 4'b0000;
  assign terminou    = r_terminou;
  assign venceu      = r_venceu;
  assign db_overflow = w_overflow;
  assign db_estado   = r_estado;
  assign db_rodada   = r_rodada;
  assign db_contagem = w_contagem;

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] leds;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       jogar;
  logic [3:0] botoes;
  logic       terminou;
  logic       venceu;
  logic       db_overflow;
  logic [3:0] db_estado;
  logic [3:0] db_rodada;
  logic [4:0] db_contagem;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  jogador_automatico #(
    .MAX_JOGADAS  (16),
    .PRESS_CYCLES (10),
    .GAP_CYCLES   (10),
    .QUIET_CYCLES (20),
    .JOGAR_CYCLES (5),
    .ERRO_RODADA  (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .leds        (leds),
    .pronto      (pronto),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
    .jogar       (jogar),
    .botoes      (botoes),
    .terminou    (terminou),
    .venceu      (venceu),
    .db_overflow (db_overflow),
    .db_estado   (db_estado),
    .db_rodada   (db_rodada),
    .db_contagem (db_contagem)
  );

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [3:0] v, input int on, input int off);
    leds = v;
    repeat (on) step();
    leds = 4'b0000;
    repeat (off) step();
  endtask

  task automatic count_jogar(input string tag);
    int n;
    n = 0;
    while (jogar === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk({tag, "_jogar_len"}, n, 5);
    chk({tag, "_estado_obs"}, db_estado, 4'h2);
  endtask

  // Waits for the next press, checks its value and width, optionally the gap.
  task automatic check_press(input string tag, input logic [3:0] exp, input bit gap);
    int  n;
    bit  achou;
    achou = (botoes != 4'b0000);
    n = 0;
    while (!achou && n < 200) begin
      step();
      n++;
      achou = (botoes != 4'b0000);
    end
    chk({tag, "_found"}, achou, 1);
    chk({tag, "_val"}, botoes, exp);
    n = 0;
    while (botoes === exp && n < 40) begin
      n++;
      step();
    end
    chk({tag, "_len"}, n, 10);
    if (gap) begin
      n = 0;
      while (db_estado === 4'h4 && botoes === 4'b0000 && n < 40) begin
        n++;
        step();
      end
      chk({tag, "_gap"}, n, 10);
    end
  endtask

  initial begin
    reset    = 1'b1;
    habilita = 1'b0;
    leds     = 4'b0000;
    pronto   = 1'b0;
    ganhou   = 1'b0;
    perdeu   = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_jogar", jogar, 0);
    chk("rst_botoes", botoes, 0);
    chk("rst_terminou", terminou, 0);
    chk("rst_venceu", venceu, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_rodada", db_rodada, 0);
    chk("rst_contagem", db_contagem, 0);
    chk("rst_overflow", db_overflow, 0);

    // Start: jogar pulse of 5 cycles, then OBSERVA.
    habilita = 1'b1;
    step();
    chk("start_estado", db_estado, 4'h1);
    count_jogar("g1");

    // Round 1: single LED.
    show(4'b0001, 3, 0);
    chk("r1_contagem", db_contagem, 1);
    check_press("r1p0", 4'b0001, 1'b1);
    chk("r1_estado_fim", db_estado, 4'h2);
    chk("r1_rodada", db_rodada, 1);

    // Round 2 is the corrupted round: first press rotated, second intact.
    show(4'b0001, 3, 5);
    show(4'b0010, 3, 0);
    chk("r2_contagem", db_contagem, 2);
    check_press("r2p0", 4'b0010, 1'b1);
    check_press("r2p1", 4'b0010, 1'b1);
    chk("r2_estado_fim", db_estado, 4'h2);
    chk("r2_rodada", db_rodada, 2);

    // Round 3: three entries replayed in order.
    show(4'b0001, 3, 5);
    show(4'b0100, 3, 5);
    show(4'b1000, 3, 0);
    chk("r3_contagem", db_contagem, 3);
    check_press("r3p0", 4'b0001, 1'b1);
    check_press("r3p1", 4'b0100, 1'b1);
    check_press("r3p2", 4'b1000, 1'b1);
    chk("r3_estado_fim", db_estado, 4'h2);
    chk("r3_rodada", db_rodada, 3);

    // Round 4: perdeu during a press.
    show(4'b0010, 3, 0);
    begin
      int n;
      n = 0;
      while (botoes === 4'b0000 && n < 200) begin
        n++;
        step();
      end
      chk("r4_press_found", (botoes != 4'b0000), 1);
    end
    step();
    step();
    chk("r4_estado_press", db_estado, 4'h3);
    perdeu = 1'b1;
    #1;
    chk("r4_botoes_forced", botoes, 0);
    step();
    chk("fim_estado", db_estado, 4'hF);
    chk("fim_terminou", terminou, 1);
    chk("fim_venceu", venceu, 0);
    chk("fim_botoes", botoes, 0);
    perdeu = 1'b0;
    step();
    chk("fim_hold", db_estado, 4'hF);
    habilita = 1'b0;
    step();
    chk("abort_estado", db_estado, 4'h0);
    chk("abort_terminou", terminou, 0);
    habilita = 1'b1;
    step();
    count_jogar("g2");

    // Non-one-hot value ignored.
    show(4'b0011, 3, 3);
    chk("nonhot_contagem", db_contagem, 0);

    // 17 captures: the last overflows and is dropped.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] v;
      v = 4'b0001 << (i % 4);
      show(v, 2, 2);
    end
    chk("ovf_flag", db_overflow, 1);
    chk("ovf_contagem", db_contagem, 16);

    for (int i = 0; i < 15; i++) begin
      logic [3:0] v;
      v = 4'b0001 << (i % 4);
      check_press($sformatf("ovf_p%0d", i), v, 1'b1);
    end
    check_press("ovf_p15", 4'b1000, 1'b0);
    chk("ovf_solta", db_estado, 4'h4);

    // Reset in the middle of SOLTA.
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_jogar", jogar, 0);
    chk("mid_rst_botoes", botoes, 0);
    chk("mid_rst_terminou", terminou, 0);
    chk("mid_rst_venceu", venceu, 0);
    chk("mid_rst_estado", db_estado, 0);
    chk("mid_rst_rodada", db_rodada, 0);
    chk("mid_rst_contagem", db_contagem, 0);
    chk("mid_rst_overflow", db_overflow, 0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
